// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types, port ids and defaults for the data-memory arbiter
package dm_arbiter_pkg;
    localparam int DM_ADDR_W   = 7;
    localparam int DM_DATA_W   = 16;
    localparam int DM_ISSUE_TO = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dm_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // A port requests only when exactly one of its strobes is high
    function automatic logic port_req(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant selection
module rr_arbiter2
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // On a tie the port that was not served last wins; otherwise the lone requester
    always_comb begin
        grant = PORT0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin arbiter in front of a single data memory
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DATA_W   = DM_DATA_W,
    parameter int ISSUE_TO = DM_ISSUE_TO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_write_data,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_busy_wait,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_write_data,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_busy_wait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_busy_wait
);

    localparam int CNT_W = $clog2(ISSUE_TO + 1);

    dm_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              wr_op_q, wr_op_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] p0_rd_q, p0_rd_d;
    logic [DATA_W-1:0] p1_rd_q, p1_rd_d;
    logic [1:0]        req;
    logic              arb_grant;
    logic              entering_done;

    assign req     = {port_req(p1_read, p1_write), port_req(p0_read, p0_write)};
    assign cnt_inc = cnt_q + CNT_W'(1);

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_q),
        .grant      (arb_grant)
    );

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= PORT0;
            last_q      <= PORT1;
            wr_op_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rd_q     <= '0;
            p1_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wr_op_q     <= wr_op_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_rd_q     <= p0_rd_d;
            p1_rd_q     <= p1_rd_d;
        end
    end

    // Next state; ISSUE gives up on busy after ISSUE_TO cycles (zero-latency memory)
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE:  if (|req) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (mem_busy_wait) begin
                    state_d = ST_WAIT;
                end else if (cnt_inc == CNT_W'(ISSUE_TO)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT:  if (!mem_busy_wait) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant latch, memory strobes, read-data capture and stall outputs
    always_comb begin
        grant_d       = grant_q;
        last_d        = last_q;
        wr_op_d       = wr_op_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        p0_rd_d       = p0_rd_q;
        p1_rd_d       = p1_rd_q;
        entering_done = (state_q == ST_ISSUE || state_q == ST_WAIT) && (state_d == ST_DONE);

        if (state_q == ST_IDLE && |req) begin
            grant_d     = arb_grant;
            wr_op_d     = (arb_grant == PORT1) ? p1_write : p0_write;
            mem_addr_d  = (arb_grant == PORT1) ? p1_address : p0_address;
            mem_wdata_d = (arb_grant == PORT1) ? p1_write_data : p0_write_data;
            mem_read_d  = ~wr_op_d;
            mem_write_d = wr_op_d;
        end

        // Capture on the way into DONE so the data is valid while busy_wait is low
        if (entering_done) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (!wr_op_q) begin
                if (grant_q == PORT1) p1_rd_d = mem_read_data;
                else                  p0_rd_d = mem_read_data;
            end
        end

        if (state_q == ST_DONE) last_d = grant_q;

        p0_busy_wait = ~rst & req[0] & ~(state_q == ST_DONE && grant_q == PORT0);
        p1_busy_wait = ~rst & req[1] & ~(state_q == ST_DONE && grant_q == PORT1);
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign p0_read_data   = p0_rd_q;
    assign p1_read_data   = p1_rd_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter with a behavioural memory and arbitration model
`timescale 1ns/1ps
module tb_dm_arbiter;
    localparam int AW = 7;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic p0_read, p0_write, p1_read, p1_write;
    logic [AW-1:0] p0_address, p1_address;
    logic [DW-1:0] p0_write_data, p1_write_data, p0_read_data, p1_read_data;
    logic p0_busy_wait, p1_busy_wait;
    logic mem_read, mem_write, mem_busy_wait;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ISSUE_TO(4)) dut (
        .clk(clk), .rst(rst),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
        .p0_write_data(p0_write_data), .p0_read_data(p0_read_data), .p0_busy_wait(p0_busy_wait),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
        .p1_write_data(p1_write_data), .p1_read_data(p1_read_data), .p1_busy_wait(p1_busy_wait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_busy_wait(mem_busy_wait)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
    typedef struct packed {logic port; logic wr; logic [DW-1:0] rd;} acc_t;

    req_t req_q[2][$];
    acc_t acc_q[$];
    int   done_hist[$];
    logic [DW-1:0] mem_arr [128];
    logic [DW-1:0] ref_mem [128];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing", name);
    endfunction

    // Memory: a rising strobe starts an access, busy for mem_lat cycles, writes land at the start
    int   mem_lat = 2;
    int   rem = 0;
    logic strobe_prev = 1'b0;
    assign mem_busy_wait = (rem != 0);
    assign mem_read_data = mem_arr[mem_address];
    always @(posedge clk) begin
        if (rst) begin
            rem <= 0;
            strobe_prev <= 1'b0;
        end else begin
            strobe_prev <= mem_read | mem_write;
            if ((mem_read | mem_write) && !strobe_prev) begin
                rem <= mem_lat;
                if (mem_write) mem_arr[mem_address] = mem_write_data;
            end else if (rem != 0) begin
                rem <= rem - 1;
            end
        end
    end

    // Monitor: predicts the winner of each access from the pending set and last winner,
    // then checks each completion against the predicted order and reference memory
    logic [1:0] pend, pend_prev;
    logic       strobe_seen, model_last, w;
    req_t       r;
    acc_t       a;
    always @(negedge clk) begin
        pend = {p1_read ^ p1_write, p0_read ^ p0_write};
        if (rst) begin
            pend_prev   = 2'b00;
            strobe_seen = 1'b0;
            model_last  = 1'b1;
            acc_q.delete();
        end else begin
            if ((mem_read | mem_write) && !strobe_seen) begin
                if (pend_prev == 2'b00) begin
                    fail_now("acc_without_request");
                end else begin
                    w = (pend_prev == 2'b11) ? ~model_last : pend_prev[1];
                    model_last = w;
                    if (req_q[int'(w)].size() == 0) begin
                        fail_now("acc_no_queued_req");
                    end else begin
                        r = req_q[int'(w)][0];
                        check("acc_write", mem_write, r.wr);
                        check("acc_read", mem_read, !r.wr);
                        check("acc_addr", mem_address, r.addr);
                        if (r.wr) begin
                            check("acc_wdata", mem_write_data, r.data);
                            ref_mem[r.addr] = r.data;
                        end
                        acc_q.push_back('{port: w, wr: r.wr, rd: ref_mem[r.addr]});
                    end
                end
            end
            strobe_seen = mem_read | mem_write;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && !((p == 1) ? p1_busy_wait : p0_busy_wait)) begin
                    if (acc_q.size() == 0) begin
                        fail_now("done_unexpected");
                    end else begin
                        a = acc_q.pop_front();
                        check("done_port", p, a.port);
                        if (!a.wr) check("rd_data", (p == 1) ? p1_read_data : p0_read_data, a.rd);
                        done_hist.push_back(p);
                    end
                end
            end
            pend_prev = pend;
        end
    end

    task automatic drive_port(input int p, input logic rd, input logic wr,
                              input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if (p == 0) begin
            p0_read = rd; p0_write = wr; p0_address = ad; p0_write_data = d;
        end else begin
            p1_read = rd; p1_write = wr; p1_address = ad; p1_write_data = d;
        end
    endtask

    // Requester: called just after a posedge; returns the number of cycles busy_wait was high
    task automatic do_req(input int p, input logic wr, input logic [AW-1:0] ad,
                          input logic [DW-1:0] d, output int busy_cyc);
        bit done = 0;
        req_q[p].push_back('{wr: wr, addr: ad, data: d});
        drive_port(p, !wr, wr, ad, d);
        busy_cyc = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (!((p == 1) ? p1_busy_wait : p0_busy_wait)) done = 1;
            else busy_cyc++;
        end
        if (!done) fail_now("busy_timeout");
        void'(req_q[p].pop_front());
        @(posedge clk); #1;
        drive_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rand_port(input int p);
        int bc;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        if ($urandom_range(0, 3) != 0)
            do_req(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), bc);
    endtask

    int bc0, bc1, base;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = DW'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        rst = 1'b1;
        drive_port(0, 1'b1, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk); @(negedge clk);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_p0_rdata", p0_read_data, 0);
        check("rst_p1_rdata", p1_read_data, 0);
        check("rst_p0_busy", p0_busy_wait, 0);
        check("rst_p1_busy", p1_busy_wait, 0);
        drive_port(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous requests after reset: port 0 first, port 1 waits for the whole transaction
        mem_lat = 2;
        fork
            do_req(0, 1'b0, 7'h05, 16'h0000, bc0);
            do_req(1, 1'b1, 7'h0C, 16'h005F, bc1);
        join
        check("tie_p0_busy", bc0, 2 + 3);
        check("tie_p1_busy", bc1, (2 + 3) + 1 + (2 + 3));
        check("tie_write_landed", mem_arr[12], 16'h005F);

        // Reset during WAIT of a port-1 write
        mem_lat = 20;
        req_q[1].push_back('{wr: 1'b1, addr: 7'h22, data: 16'h1234});
        drive_port(1, 1'b0, 1'b1, 7'h22, 16'h1234);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_mem_write", mem_write, 0);
        check("abort_mem_read", mem_read, 0);
        check("abort_p1_busy", p1_busy_wait, 0);
        check("abort_p1_rdata", p1_read_data, 0);
        @(negedge clk);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        req_q[1].delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Long memory access after reset
        mem_arr[12] = 16'h412D;
        ref_mem[12] = 16'h412D;
        mem_lat = 98;
        do_req(1, 1'b0, 7'h0C, 16'h0000, bc1);
        check("long_p1_busy", bc1, 98 + 3);
        check("long_p1_rdata", p1_read_data, 16'h412D);
        check("long_p0_rdata", p0_read_data, 0);

        // Both ports reading back-to-back alternate grants
        mem_lat = 2;
        base = done_hist.size();
        fork
            begin do_req(0, 1'b0, 7'h01, '0, bc0); do_req(0, 1'b0, 7'h02, '0, bc0); end
            begin do_req(1, 1'b0, 7'h03, '0, bc1); do_req(1, 1'b0, 7'h04, '0, bc1); end
        join
        if (done_hist.size() < base + 4) fail_now("rr_history_short");
        else for (int i = 0; i < 4; i++) check("rr_order", done_hist[base + i], i % 2);

        // Memory that never raises busy: DONE after four ISSUE cycles
        mem_lat = 0;
        mem_arr[7'h33] = 16'hBEEF;
        ref_mem[7'h33] = 16'hBEEF;
        do_req(0, 1'b0, 7'h33, '0, bc0);
        check("zero_lat_busy", bc0, 1 + 4);
        check("zero_lat_rdata", p0_read_data, 16'hBEEF);

        // Read and write together is no request
        drive_port(0, 1'b1, 1'b1, 7'h10, 16'hAAAA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("both_strobes_mem_read", mem_read, 0);
            check("both_strobes_mem_write", mem_write, 0);
            check("both_strobes_busy", p0_busy_wait, 0);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, '0, '0);

        // Randomised traffic on both ports
        for (int it = 0; it < 40; it++) begin
            mem_lat = $urandom_range(0, 5);
            fork
                rand_port(0);
                rand_port(1);
            join
            @(posedge clk); #1;
        end
        repeat (3) @(negedge clk);
        check("acc_queue_drained", acc_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
